// File: rtl/mac_pkg.sv
// Shared types and constants for the Booth-multiplier MAC accumulator.
// Optional saturation (MAC_SATURATE_EN) uses the limit helpers defined here.
package mac_pkg;

  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Limits are returned in 32 bits; callers keep the low w bits.
  function automatic logic [31:0] sat_min(input int w);
    return 32'hFFFF_FFFF << (w - 1);
  endfunction

  function automatic logic [31:0] sat_max(input int w);
    return ~(32'hFFFF_FFFF << (w - 1));
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational signed add of accumulator plus sign-extended product with overflow detect.
// With MAC_SATURATE_EN defined the sum clamps on overflow, otherwise it wraps.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [ACC_W-1:0]  sum_o,
  output logic                     ovf_o
);

  localparam int SUM_W = ACC_W + 1;

`ifdef MAC_SATURATE_EN
  localparam logic [31:0] MAX32 = sat_max(ACC_W);
  localparam logic [31:0] MIN32 = sat_min(ACC_W);
  localparam logic signed [ACC_W-1:0] SAT_MAX = MAX32[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] SAT_MIN = MIN32[ACC_W-1:0];
`endif

  logic signed [SUM_W-1:0] acc_ext_s;
  logic signed [SUM_W-1:0] prod_ext_s;
  logic signed [SUM_W-1:0] sum_wide_s;

  // Overflow: operands share a sign that the truncated result does not.
  always_comb begin
    acc_ext_s  = SUM_W'(acc_i);
    prod_ext_s = SUM_W'(prod_i);
    sum_wide_s = acc_ext_s + prod_ext_s;
    ovf_o      = (acc_i[ACC_W-1] == prod_i[PROD_W-1]) &&
                 (sum_wide_s[ACC_W-1] != acc_i[ACC_W-1]);
`ifdef MAC_SATURATE_EN
    if (ovf_o) begin
      sum_o = prod_i[PROD_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_o = sum_wide_s[ACC_W-1:0];
    end
`else
    sum_o = sum_wide_s[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/booth_mac_accumulator.sv
// Sums a job of signed 16-bit products into a wide accumulator with sticky overflow.
// Build option MAC_SATURATE_EN selects clamping instead of wrapping (see mac_sat_add).
module booth_mac_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              prod_valid_i,
  output logic              prod_ready_o,
  output logic [ACC_W-1:0]  acc_o,
  output logic              acc_valid_o,
  input  logic              acc_ready_i,
  output logic              busy_o,
  output logic              ovf_o
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum_s;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    add_ovf_s;
  logic                    beat_s;

  assign beat_s = prod_valid_i && (state_q == ST_ACCUM);

  mac_sat_add #(.ACC_W(ACC_W)) u_add (
    .acc_i  (acc_q),
    .prod_i (prod_i),
    .sum_o  (sum_s),
    .ovf_o  (add_ovf_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start_i only matters in IDLE; an empty job goes straight to HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (len_i == '0) ? ST_HOLD : ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (beat_s && (cnt_q == CNT_W'(1))) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (acc_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          acc_d = '0;
          cnt_d = len_i;
          ovf_d = 1'b0;
        end else begin
          acc_d = acc_q;
        end
      end
      ST_ACCUM: begin
        if (beat_s) begin
          acc_d = sum_s;
          cnt_d = cnt_q - CNT_W'(1);
          ovf_d = ovf_q | add_ovf_s;
        end else begin
          acc_d = acc_q;
        end
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    prod_ready_o = (state_q == ST_ACCUM);
    acc_valid_o  = (state_q == ST_HOLD);
    busy_o       = (state_q != ST_IDLE);
    acc_o        = acc_q;
    ovf_o        = ovf_q;
  end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Scoreboard bench: instance A (ACC_W=24) for functional jobs, instance B (ACC_W=16) for overflow.
// Expected results are pushed at job start and popped by per-instance monitors on result handshake.
module tb_booth_mac_accumulator;

  typedef struct {
    longint acc;
    logic   ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic [7:0]  len_i = 8'd0;
  logic [15:0] prod_i = 16'd0;
  logic prod_valid_i = 1'b0;
  logic acc_ready_i = 1'b1;

  logic               prod_ready_a, acc_valid_a, busy_a, ovf_a;
  logic signed [23:0] acc_a;
  logic               prod_ready_b, acc_valid_b, busy_b, ovf_b;
  logic signed [15:0] acc_b;

  int tests = 0;
  int failed = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  booth_mac_accumulator #(.ACC_W(24), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .len_i(len_i),
    .prod_i(prod_i), .prod_valid_i(prod_valid_i), .prod_ready_o(prod_ready_a),
    .acc_o(acc_a), .acc_valid_o(acc_valid_a), .acc_ready_i(acc_ready_i),
    .busy_o(busy_a), .ovf_o(ovf_a)
  );

  booth_mac_accumulator #(.ACC_W(16), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .len_i(len_i),
    .prod_i(prod_i), .prod_valid_i(prod_valid_i), .prod_ready_o(prod_ready_b),
    .acc_o(acc_b), .acc_valid_o(acc_valid_b), .acc_ready_i(acc_ready_i),
    .busy_o(busy_b), .ovf_o(ovf_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Result monitors: compare against the oldest expectation on every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (acc_valid_a && acc_ready_i) begin
      if (qa.size() == 0) begin
        check("a_unexpected_result", 1, 0);
      end else begin
        e = qa.pop_front();
        check("a_acc", acc_a, e.acc);
        check("a_ovf", ovf_a, e.ovf);
      end
    end
    if (acc_valid_b && acc_ready_i) begin
      if (qb.size() == 0) begin
        check("b_unexpected_result", 1, 0);
      end else begin
        e = qb.pop_front();
        check("b_acc", acc_b, e.acc);
        check("b_ovf", ovf_b, e.ovf);
      end
    end
  end

  task automatic push(input bit sel_b, input longint acc, input logic ovf);
    exp_t e;
    e.acc = acc;
    e.ovf = ovf;
    if (sel_b) qb.push_back(e);
    else       qa.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input bit sel_b, input int len);
    len_i = len[7:0];
    if (sel_b) start_b = 1'b1;
    else       start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic beat(input bit sel_b, input int p);
    bit acc_ok;
    int n;
    n = 0;
    prod_i = p[15:0];
    prod_valid_i = 1'b1;
    do begin
      acc_ok = sel_b ? prod_ready_b : prod_ready_a;
      tick();
      n++;
    end while (!acc_ok && n < 20);
    prod_valid_i = 1'b0;
    check("beat_accepted", acc_ok, 1);
  endtask

  task automatic wait_idle(input bit sel_b);
    int n;
    n = 0;
    while ((sel_b ? busy_b : busy_a) && n < 50) begin
      tick();
      n++;
    end
    check("idle_reached", sel_b ? busy_b : busy_a, 0);
  endtask

  initial begin
    #12;
    check("rst_acc", acc_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_prod_ready", prod_ready_a, 0);
    check("rst_acc_valid", acc_valid_a, 0);
    check("rst_busy", busy_a, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic job: 100 - 250 + 7
    push(0, -143, 1'b0);
    start_job(0, 3);
    check("busy_in_job", busy_a, 1);
    beat(0, 100);
    beat(0, -250);
    check("no_early_valid", acc_valid_a, 0);
    beat(0, 7);
    check("valid_after_last_beat", acc_valid_a, 1);
    wait_idle(0);

    // Bubbles plus backpressure in HOLD
    push(0, 128, 1'b0);
    start_job(0, 4);
    beat(0, 16384);
    tick(); tick();
    beat(0, -16256);
    tick();
    acc_ready_i = 1'b0;
    beat(0, 1);
    beat(0, -1);
    prod_i = 16'd50;
    prod_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", acc_valid_a, 1);
      check("hold_acc", acc_a, 128);
      check("hold_prod_ready", prod_ready_a, 0);
      tick();
    end
    prod_valid_i = 1'b0;
    acc_ready_i = 1'b1;
    wait_idle(0);

    // Overflow on the 16-bit instance
`ifdef MAC_SATURATE_EN
    push(1, 32767, 1'b1);
`else
    push(1, -32768, 1'b1);
`endif
    start_job(1, 2);
    beat(1, 16384);
    beat(1, 16384);
    check("ovf_set", ovf_b, 1);
    wait_idle(1);
    push(1, 5, 1'b0);
    start_job(1, 1);
    check("ovf_cleared_by_start", ovf_b, 0);
    beat(1, 5);
    wait_idle(1);

    // Empty job
    push(0, 0, 1'b0);
    prod_i = 16'd999;
    prod_valid_i = 1'b1;
    start_job(0, 0);
    check("empty_valid", acc_valid_a, 1);
    check("empty_acc", acc_a, 0);
    check("empty_no_ready", prod_ready_a, 0);
    prod_valid_i = 1'b0;
    wait_idle(0);

    // Starts while busy are ignored
    push(0, 60, 1'b0);
    start_job(0, 3);
    beat(0, 10);
    len_i = 8'd1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    beat(0, 20);
    beat(0, 30);
    check("hold_reached", acc_valid_a, 1);
    len_i = 8'd5;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("start_in_hold_ignored", busy_a, 0);

    // Full-length job
    push(0, -4145280, 1'b0);
    start_job(0, 255);
    for (int i = 0; i < 255; i++) beat(0, -16256);
    check("full_valid", acc_valid_a, 1);
    wait_idle(0);

    // Asynchronous reset mid-job
    start_job(0, 5);
    beat(0, 1);
    beat(0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_acc", acc_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_ready", prod_ready_a, 0);
    check("midrst_valid", acc_valid_a, 0);
    check("midrst_ovf", ovf_a, 0);
    check("midrst_b_acc", acc_b, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", busy_a, 0);
    push(0, 5, 1'b0);
    start_job(0, 1);
    beat(0, 5);
    wait_idle(0);

    tick();
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
